// File: rtl/compressor_tree_pipe_if.sv
// Stream bundle for the carry-save reduction tree: the operand side, the sum/carry
// side and the flush strobe, as seen by the producer (master) and by the tree (slave).
interface compressor_tree_pipe_if #(
  parameter int WIDTH = 98,
  parameter int N_OPS = 16
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [N_OPS*WIDTH-1:0]   in_ops;
  logic [7:0]               in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_sum;
  logic [WIDTH-1:0]         out_carry;
  logic [7:0]               out_tag;
  logic                     flush;

  modport master (
    output in_valid, in_ops, in_tag, out_ready, flush,
    input  in_ready, out_valid, out_sum, out_carry, out_tag
  );

  modport slave (
    input  in_valid, in_ops, in_tag, out_ready, flush,
    output in_ready, out_valid, out_sum, out_carry, out_tag
  );
endinterface

// File: rtl/compressor_tree_pipe.sv
// Pipelined 4-2 compressor tree: reduces N_OPS operands to a sum/carry pair, one
// register stage per level, with a valid/ready pipeline that stalls without bubbles.
module compressor_tree_pipe #(
  parameter int WIDTH = 98,
  parameter int N_OPS = 16
) (
  input logic                 clk,
  input logic                 rst,
  compressor_tree_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(N_OPS) - 1;

  if ((N_OPS != 4) && (N_OPS != 8) && (N_OPS != 16)) begin : g_bad_n_ops
    $error("compressor_tree_pipe: N_OPS must be 4, 8 or 16");
  end

  // Returns {shifted carry, sum}; the internal E chain feeds the neighbour bit, top E bit is dropped.
  function automatic logic [2*WIDTH-1:0] compress42(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] ab_s;
    logic [WIDTH-1:0] e_s;
    logic [WIDTH-1:0] ein_s;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] co_s;
    ab_s  = a ^ b;
    e_s   = (ab_s & c) | (~ab_s & a);
    ein_s = e_s << 1'b1;
    x_s   = ab_s ^ c ^ d;
    co_s  = (~x_s & d) | (ein_s & x_s);
    return {co_s << 1'b1, x_s ^ ein_s};
  endfunction

  genvar k;
  for (k = 0; k < LEVELS; k++) begin : g_stage
    localparam int N_IN  = 2 ** (LEVELS + 1 - k);
    localparam int N_OUT = N_IN / 2;

    logic [N_IN*WIDTH-1:0]  src_s;
    logic                   src_valid_s;
    logic [7:0]             src_tag_s;
    logic [N_OUT*WIDTH-1:0] red_s;
    logic [N_OUT*WIDTH-1:0] data_r;
    logic                   valid_r;
    logic [7:0]             tag_r;
    logic                   ready_s;
    logic                   next_ready_s;

    if (k == 0) begin : g_src
      assign src_s       = bus.in_ops;
      assign src_valid_s = bus.in_valid;
      assign src_tag_s   = bus.in_tag;
    end else begin : g_src
      assign src_s       = g_stage[k-1].data_r;
      assign src_valid_s = g_stage[k-1].valid_r;
      assign src_tag_s   = g_stage[k-1].tag_r;
    end

    if (k == LEVELS - 1) begin : g_next
      assign next_ready_s = bus.out_ready;
    end else begin : g_next
      assign next_ready_s = g_stage[k+1].ready_s;
    end

    // A stage may load whenever it is empty or its successor is taking its content.
    assign ready_s = ~valid_r | next_ready_s;

    // One reduction level: each group of four vectors yields sum at 2g, carry at 2g+1.
    always_comb begin
      red_s = '0;
      for (int g = 0; g < N_IN / 4; g++) begin
        red_s[2*g*WIDTH +: 2*WIDTH] = compress42(src_s[(4*g)*WIDTH +: WIDTH],
                                                 src_s[(4*g+1)*WIDTH +: WIDTH],
                                                 src_s[(4*g+2)*WIDTH +: WIDTH],
                                                 src_s[(4*g+3)*WIDTH +: WIDTH]);
      end
    end

    // Stage register: flush only drops validity, stale data may linger.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        data_r  <= '0;
        tag_r   <= 8'h00;
      end else if (bus.flush) begin
        valid_r <= 1'b0;
      end else if (ready_s) begin
        valid_r <= src_valid_s;
        data_r  <= red_s;
        tag_r   <= src_tag_s;
      end
    end
  end

  assign bus.in_ready  = g_stage[0].ready_s & ~bus.flush;
  assign bus.out_valid = g_stage[LEVELS-1].valid_r;
  assign bus.out_sum   = g_stage[LEVELS-1].data_r[WIDTH-1:0];
  assign bus.out_carry = g_stage[LEVELS-1].data_r[2*WIDTH-1:WIDTH];
  assign bus.out_tag   = g_stage[LEVELS-1].tag_r;
endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Bench for compressor_tree_pipe: three instances (4, 8, 16 operands) checked against an
// arithmetic scoreboard (operand sum mod 2^WIDTH plus tag order) and directed literals.
module tb_compressor_tree_pipe;
  localparam int MAXB = 16 * 98;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compressor_tree_pipe_if #(.WIDTH(8),  .N_OPS(4))  if4 ();
  compressor_tree_pipe_if #(.WIDTH(16), .N_OPS(8))  if8 ();
  compressor_tree_pipe_if #(.WIDTH(98), .N_OPS(16)) if16 ();

  compressor_tree_pipe #(.WIDTH(8),  .N_OPS(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  compressor_tree_pipe #(.WIDTH(16), .N_OPS(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  compressor_tree_pipe #(.WIDTH(98), .N_OPS(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  typedef struct {
    logic [127:0] sum;
    logic [7:0]   tag;
  } exp_t;

  exp_t         exp_q [3][$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           pops [3];
  int           pushes [3];
  logic         prev_stall [3];
  logic [127:0] prev_sum [3];
  logic [127:0] prev_carry [3];
  logic [7:0]   prev_tag [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference: plain sum of all operands modulo 2^w.
  function automatic logic [127:0] model_sum(input logic [MAXB-1:0] ops, input int n, input int w);
    logic [127:0] mask;
    logic [127:0] acc;
    mask = (128'd1 << w) - 128'd1;
    acc  = '0;
    for (int i = 0; i < n; i++) acc = acc + (128'(ops >> (i * w)) & mask);
    return acc & mask;
  endfunction

  task automatic observe(input int d, input int n, input int w, input logic fl,
                         input logic in_valid, input logic in_ready,
                         input logic [MAXB-1:0] ops, input logic [7:0] in_tag,
                         input logic out_valid, input logic out_ready,
                         input logic [127:0] sum, input logic [127:0] carry,
                         input logic [7:0] tag);
    string        nm;
    logic [127:0] mask;
    exp_t         e;
    nm   = $sformatf("dut%0d", n);
    mask = (128'd1 << w) - 128'd1;
    if (rst) begin
      exp_q[d].delete();
      prev_stall[d] = 1'b0;
      return;
    end
    if (prev_stall[d]) begin
      check({nm, "_stall_valid"}, 128'(out_valid), 128'd1);
      check({nm, "_stall_sum"},   sum,   prev_sum[d]);
      check({nm, "_stall_carry"}, carry, prev_carry[d]);
      check({nm, "_stall_tag"},   128'(tag), 128'(prev_tag[d]));
    end
    if (fl) begin
      exp_q[d].delete();
      prev_stall[d] = 1'b0;
      return;
    end
    if (out_valid && out_ready) begin
      pops[d]++;
      if (exp_q[d].size() == 0) begin
        check({nm, "_spurious_out"}, 128'(out_valid), 128'd0);
      end else begin
        e = exp_q[d].pop_front();
        check({nm, "_sum"}, (sum + carry) & mask, e.sum);
        check({nm, "_tag"}, 128'(tag), 128'(e.tag));
      end
    end
    if (in_valid && in_ready) begin
      e.sum = model_sum(ops, n, w);
      e.tag = in_tag;
      exp_q[d].push_back(e);
      pushes[d]++;
    end
    prev_stall[d] = out_valid && !out_ready;
    prev_sum[d]   = sum;
    prev_carry[d] = carry;
    prev_tag[d]   = tag;
  endtask

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    observe(0, 4, 8, if4.flush, if4.in_valid, if4.in_ready, MAXB'(if4.in_ops), if4.in_tag,
            if4.out_valid, if4.out_ready, 128'(if4.out_sum), 128'(if4.out_carry), if4.out_tag);
    observe(1, 8, 16, if8.flush, if8.in_valid, if8.in_ready, MAXB'(if8.in_ops), if8.in_tag,
            if8.out_valid, if8.out_ready, 128'(if8.out_sum), 128'(if8.out_carry), if8.out_tag);
    observe(2, 16, 98, if16.flush, if16.in_valid, if16.in_ready, MAXB'(if16.in_ops), if16.in_tag,
            if16.out_valid, if16.out_ready, 128'(if16.out_sum), 128'(if16.out_carry), if16.out_tag);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops16();
    for (int j = 0; j < 49; j++) if16.in_ops[j*32 +: 32] = $urandom();
  endtask

  logic [7:0]  s8;
  logic [97:0] s98;
  int          acc;
  int          guard;
  int          saved_pops;

  initial begin
    for (int d = 0; d < 3; d++) begin
      pops[d] = 0; pushes[d] = 0; prev_stall[d] = 1'b0;
    end
    if4.in_valid = 1'b0;  if4.out_ready = 1'b1;  if4.flush = 1'b0;  if4.in_ops = '0;  if4.in_tag = 8'h00;
    if8.in_valid = 1'b0;  if8.out_ready = 1'b1;  if8.flush = 1'b0;  if8.in_ops = '0;  if8.in_tag = 8'h00;
    if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.flush = 1'b0; if16.in_ops = '0; if16.in_tag = 8'h00;

    // Reset state
    #2;
    check("rst_valid4",   128'(if4.out_valid), 128'd0);
    check("rst_valid8",   128'(if8.out_valid), 128'd0);
    check("rst_valid16",  128'(if16.out_valid), 128'd0);
    check("rst_sum16",    128'(if16.out_sum), 128'd0);
    check("rst_carry16",  128'(if16.out_carry), 128'd0);
    check("rst_tag16",    128'(if16.out_tag), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: four 0xFF operands, one-cycle latency
    if4.in_ops = {4{8'hFF}};
    if4.in_tag = 8'hA5;
    if4.in_valid = 1'b1;
    #1 check("t1_in_ready", 128'(if4.in_ready), 128'd1);
    tick();
    if4.in_valid = 1'b0;
    s8 = if4.out_sum + if4.out_carry;
    check("t1_valid", 128'(if4.out_valid), 128'd1);
    check("t1_sum",   128'(s8), 128'hFC);
    check("t1_tag",   128'(if4.out_tag), 128'hA5);
    tick();

    // Test 2: operand i = i+1, three-cycle latency, then a back-to-back random stream
    for (int i = 0; i < 16; i++) if16.in_ops[i*98 +: 98] = 98'(i + 1);
    if16.in_tag = 8'h22;
    if16.in_valid = 1'b1;
    tick();
    if16.in_valid = 1'b0;
    tick();
    check("t2_not_early", 128'(if16.out_valid), 128'd0);
    tick();
    s98 = if16.out_sum + if16.out_carry;
    check("t2_valid", 128'(if16.out_valid), 128'd1);
    check("t2_sum",   128'(s98), 128'd136);
    check("t2_tag",   128'(if16.out_tag), 128'h22);
    for (int t = 0; t < 1000; t++) begin
      rand_ops16();
      if16.in_tag = 8'(t);
      if16.in_valid = 1'b1;
      tick();
    end
    if16.in_valid = 1'b0;
    tick(); tick(); tick();
    check("t2_stream_count", 128'(pops[2]), 128'd1001);
    check("t2_stream_drained", 128'(exp_q[2].size()), 128'd0);

    // Test 3: backpressure fills the 8-operand pipe, then drains in order
    if8.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      if8.in_valid = 1'b1;
      if8.in_tag = 8'(acc + 1);
      for (int i = 0; i < 8; i++) if8.in_ops[i*16 +: 16] = 16'((acc + 1) * 16'h1111 + i * 16'h0123);
      #1;
      if (if8.in_ready) acc++;
      @(posedge clk); #1;
    end
    check("t3_accepted_before_full", 128'(acc), 128'd2);
    check("t3_in_ready_low", 128'(if8.in_ready), 128'd0);
    if8.out_ready = 1'b1;
    guard = 0;
    while (acc < 6 && guard < 50) begin
      if8.in_valid = 1'b1;
      if8.in_tag = 8'(acc + 1);
      for (int i = 0; i < 8; i++) if8.in_ops[i*16 +: 16] = 16'((acc + 1) * 16'h1111 + i * 16'h0123);
      #1;
      if (if8.in_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    if8.in_valid = 1'b0;
    repeat (4) tick();
    check("t3_emitted", 128'(pops[1]), 128'd6);
    check("t3_drained", 128'(exp_q[1].size()), 128'd0);

    // Test 4: random backpressure against a continuous stream
    for (int t = 0; t < 200; t++) begin
      rand_ops16();
      if16.in_tag = 8'(t + 8'h80);
      if16.in_valid = 1'b1;
      if16.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    repeat (5) tick();
    check("t4_drained", 128'(exp_q[2].size()), 128'd0);
    check("t4_balance", 128'(pops[2]), 128'(pushes[2]));

    // Test 5: asynchronous reset with three transactions in flight
    if16.out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      rand_ops16();
      if16.in_tag = 8'(8'h31 + t);
      if16.in_valid = 1'b1;
      tick();
    end
    if16.in_valid = 1'b0;
    check("t5_full_before_rst", 128'(if16.out_valid), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 128'(if16.out_valid), 128'd0);
    check("t5_rst_sum",   128'(if16.out_sum), 128'd0);
    check("t5_rst_carry", 128'(if16.out_carry), 128'd0);
    check("t5_rst_tag",   128'(if16.out_tag), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) if16.in_ops[i*98 +: 98] = 98'd1;
    if16.in_tag = 8'h55;
    if16.out_ready = 1'b1;
    if16.in_valid = 1'b1;
    tick();
    if16.in_valid = 1'b0;
    tick(); tick();
    s98 = if16.out_sum + if16.out_carry;
    check("t5_valid", 128'(if16.out_valid), 128'd1);
    check("t5_sum",   128'(s98), 128'd16);
    check("t5_tag",   128'(if16.out_tag), 128'h55);
    tick();

    // Test 6: flush two in-flight transactions while an input is offered
    if16.out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      rand_ops16();
      if16.in_tag = 8'(8'h61 + t);
      if16.in_valid = 1'b1;
      tick();
    end
    saved_pops = pops[2];
    if16.in_tag = 8'hEE;
    if16.flush = 1'b1;
    #1 check("t6_in_ready_flush", 128'(if16.in_ready), 128'd0);
    tick();
    check("t6_valid_after_flush", 128'(if16.out_valid), 128'd0);
    if16.flush = 1'b0;
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    repeat (6) tick();
    check("t6_nothing_emitted", 128'(pops[2]), 128'(saved_pops));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
